// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default widths,
// stall counter width and the occupancy state encoding.
package ex_mem_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int DEST_W_DEF  = 4;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ex_mem_state_e;

endpackage

// File: rtl/ex_mem_payload_reg.sv
// Load-enabled payload register with its own valid bit. Clearing drops the
// valid bit but keeps the data, so downstream data outputs hold their value.
module ex_mem_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with an optional skid entry so that in_ready can
// come straight from a flop instead of depending on out_ready.
module ex_mem_skid_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int SKID   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   wb_en,
    input  logic                   mem_read_en,
    input  logic                   mem_write_en,
    input  logic [DATA_W-1:0]      alu_res,
    input  logic [DATA_W-1:0]      val_rm,
    input  logic [DEST_W-1:0]      dest,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   wb_en_out,
    output logic                   mem_read_en_out,
    output logic                   mem_write_en_out,
    output logic [DATA_W-1:0]      alu_res_out,
    output logic [DATA_W-1:0]      val_rm_out,
    output logic [DEST_W-1:0]      dest_out,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int PAY_W = 3 + 2 * DATA_W + DEST_W;

    logic [PAY_W-1:0]       w_in_pay;
    logic [PAY_W-1:0]       w_m_pay;
    logic [PAY_W-1:0]       w_s_pay;
    logic [PAY_W-1:0]       w_m_d;
    logic                   w_m_valid;
    logic                   w_s_valid;
    logic                   w_accept;
    logic                   w_xfer;
    logic                   w_m_load;
    logic                   w_m_clear;
    logic                   w_m_from_s;
    logic                   w_s_load;
    logic                   w_s_clear;
    logic                   w_wb;
    logic                   w_rd;
    logic                   w_wr;
    ex_mem_state_e          w_state;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_in_pay = {wb_en, mem_read_en, mem_write_en, alu_res, val_rm, dest};

    // With the skid entry, readiness depends only on the skid valid flop.
    assign in_ready = (SKID != 0) ? !w_s_valid : (!w_m_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = w_m_valid && out_ready;

    always_comb begin
        w_state = EMPTY;
        if (w_s_valid) begin
            w_state = FULL;
        end else if (w_m_valid) begin
            w_state = ONE;
        end
    end

    always_comb begin
        w_m_load   = 1'b0;
        w_m_clear  = 1'b0;
        w_m_from_s = 1'b0;
        w_s_load   = 1'b0;
        w_s_clear  = 1'b0;
        if (flush) begin
            w_m_clear = 1'b1;
            w_s_clear = 1'b1;
        end else begin
            case (w_state)
                EMPTY: begin
                    w_m_load = w_accept;
                end
                ONE: begin
                    if (w_accept && w_xfer) begin
                        w_m_load = 1'b1;
                    end else if (w_xfer) begin
                        w_m_clear = 1'b1;
                    end else if (w_accept) begin
                        w_s_load = 1'b1;
                    end
                end
                FULL: begin
                    if (w_xfer) begin
                        w_m_load   = 1'b1;
                        w_m_from_s = 1'b1;
                        w_s_clear  = 1'b1;
                    end
                end
                default: begin
                    w_m_clear = 1'b1;
                    w_s_clear = 1'b1;
                end
            endcase
        end
    end

    assign w_m_d = w_m_from_s ? w_s_pay : w_in_pay;

    ex_mem_payload_reg #(.W(PAY_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_d),
        .o_valid (w_m_valid),
        .o_data  (w_m_pay)
    );

    generate
        if (SKID != 0) begin : g_skid
            ex_mem_payload_reg #(.W(PAY_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_s_load),
                .i_clear (w_s_clear),
                .i_data  (w_in_pay),
                .o_valid (w_s_valid),
                .o_data  (w_s_pay)
            );
        end else begin : g_no_skid
            assign w_s_valid = 1'b0;
            assign w_s_pay   = '0;
        end
    endgenerate

    assign {w_wb, w_rd, w_wr, alu_res_out, val_rm_out, dest_out} = w_m_pay;
    assign out_valid        = w_m_valid;
    assign wb_en_out        = w_wb && w_m_valid;
    assign mem_read_en_out  = w_rd && w_m_valid;
    assign mem_write_en_out = w_wr && w_m_valid;
    assign occupancy        = {1'b0, w_m_valid} + {1'b0, w_s_valid};

    // Back-pressure counter saturates rather than wrapping; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_m_valid && !out_ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: a queue-based reference model for the SKID=1
// instance plus directed checks on a second SKID=0 instance.
module tb_ex_mem_skid_reg;
    import ex_mem_pkg::*;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int PW = 3 + 2 * DW + TW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_valid0;
    logic          out_ready, out_ready0;
    logic          wb_en, mem_read_en, mem_write_en, flush;
    logic [DW-1:0] alu_res, val_rm;
    logic [TW-1:0] dest;

    logic          in_ready, out_valid, wb_en_out, mem_read_en_out, mem_write_en_out;
    logic [DW-1:0] alu_res_out, val_rm_out;
    logic [TW-1:0] dest_out;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          in_ready0, out_valid0, wb_en_out0, mem_read_en_out0, mem_write_en_out0;
    logic [DW-1:0] alu_res_out0, val_rm_out0;
    logic [TW-1:0] dest_out0;
    logic [1:0]    occupancy0;
    logic [15:0]   stall_cnt0;

    logic [PW-1:0] in_pay, out_pay;
    logic [PW-1:0] q[$];
    int            mstall;
    int            tests;
    int            fails;

    always #5 clk = ~clk;

    assign in_pay  = {wb_en, mem_read_en, mem_write_en, alu_res, val_rm, dest};
    assign out_pay = {wb_en_out, mem_read_en_out, mem_write_en_out, alu_res_out, val_rm_out, dest_out};

    ex_mem_skid_reg #(.DATA_W(DW), .DEST_W(TW), .SKID(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_en(wb_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .wb_en_out(wb_en_out),
        .mem_read_en_out(mem_read_en_out), .mem_write_en_out(mem_write_en_out),
        .alu_res_out(alu_res_out), .val_rm_out(val_rm_out), .dest_out(dest_out),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    ex_mem_skid_reg #(.DATA_W(DW), .DEST_W(TW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .wb_en(wb_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready0), .wb_en_out(wb_en_out0),
        .mem_read_en_out(mem_read_en_out0), .mem_write_en_out(mem_write_en_out0),
        .alu_res_out(alu_res_out0), .val_rm_out(val_rm_out0), .dest_out(dest_out0),
        .occupancy(occupancy0), .stall_cnt(stall_cnt0)
    );

    // Reference: a FIFO of at most two entries, advanced once per clock edge.
    task automatic model_step();
        bit xf;
        bit acc;
        xf  = (q.size() > 0) && out_ready;
        acc = in_valid && (q.size() < 2);
        if ((q.size() > 0) && !out_ready && (mstall < 65535)) mstall++;
        if (flush) begin
            q.delete();
        end else begin
            if (xf) void'(q.pop_front());
            if (acc) q.push_back(in_pay);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_payload(input logic [DW-1:0] a, input logic [TW-1:0] d);
        wb_en        = 1'b1;
        mem_read_en  = a[0];
        mem_write_en = 1'b1;
        alu_res      = a;
        val_rm       = ~a;
        dest         = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
        tests++; if (stall_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        tests++; if (out_pay !== '0) begin fails++; $display("[TB] FAIL reset_payload got %h want 0", out_pay); end
        tests++; if (in_ready0 !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready_noskid got %0b want 1", in_ready0); end
        rst = 1'b0;
        q.delete();
        mstall = 0;
        @(negedge clk);
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_payload(32'h11 * (i + 1), 4'(i + 1));
            #1;
            if (i > 0) begin
                tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL stream_valid got %0b want 1", out_valid); end
                tests++; if (alu_res_out !== 32'h11 * i) begin fails++; $display("[TB] FAIL stream_alu got %h want %h", alu_res_out, 32'h11 * i); end
                tests++; if (dest_out !== 4'(i)) begin fails++; $display("[TB] FAIL stream_dest got %0d want %0d", dest_out, i); end
            end
            tests++; if (occupancy > 2'd1) begin fails++; $display("[TB] FAIL stream_occupancy got %0d want <=1", occupancy); end
            model_step();
        end
        in_valid = 1'b0;
        #1;
        tests++; if (alu_res_out !== 32'h33) begin fails++; $display("[TB] FAIL stream_last got %h want 33", alu_res_out); end
        model_step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stream_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got[$];
        logic [DW-1:0] want[3];
        bit            c_taken;
        want = '{32'hA, 32'hB, 32'hC};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_payload(want[i], 4'(i + 5));
            #1;
            if (i == 2) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready got %0b want 0", in_ready); end
                tests++; if (occupancy !== 2'd2) begin fails++; $display("[TB] FAIL bp_occupancy got %0d want 2", occupancy); end
            end
            model_step();
        end
        #1;
        model_step();
        tests++; if (stall_cnt !== 16'(mstall)) begin fails++; $display("[TB] FAIL bp_stall_cnt got %0d want %0d", stall_cnt, mstall); end
        out_ready = 1'b1;
        c_taken = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = !c_taken;
            #1;
            if (out_valid && out_ready) got.push_back(alu_res_out);
            if (in_valid && (q.size() < 2)) c_taken = 1'b1;
            model_step();
        end
        in_valid = 1'b0;
        tests++; if (got.size() !== 3) begin fails++; $display("[TB] FAIL bp_count got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== want[i]) begin
                fails++;
                $display("[TB] FAIL bp_order idx %0d got %h want %h", i, (i < got.size()) ? got[i] : 'x, want[i]);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            set_payload(32'h500 + i, 4'(i));
            model_step();
        end
        flush = 1'b1;
        set_payload(32'h5FF, 4'd9);
        model_step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        tests++; if (occupancy !== 2'd0) begin fails++; $display("[TB] FAIL flush_occupancy got %0d want 0", occupancy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_out_valid got %0b want 0", out_valid); end
        tests++; if (wb_en_out !== 1'b0) begin fails++; $display("[TB] FAIL flush_wb_en got %0b want 0", wb_en_out); end
        tests++; if (mem_write_en_out !== 1'b0) begin fails++; $display("[TB] FAIL flush_mem_wr got %0b want 0", mem_write_en_out); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_in_ready got %0b want 1", in_ready); end
        tests++; if (stall_cnt !== 16'(mstall)) begin fails++; $display("[TB] FAIL flush_keeps_stall got %0d want %0d", stall_cnt, mstall); end
        model_step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            set_payload(32'h700 + i, 4'(i));
            model_step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL async_out_valid got %0b want 0", out_valid); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("[TB] FAIL async_occupancy got %0d want 0", occupancy); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL async_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        mstall = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            wb_en        = 1'($urandom);
            mem_read_en  = 1'($urandom);
            mem_write_en = 1'($urandom);
            alu_res      = $urandom;
            val_rm       = $urandom;
            dest         = 4'($urandom);
            #1;
            tests++; if (out_valid !== (q.size() > 0)) begin fails++; $display("[TB] FAIL rnd_out_valid cyc %0d got %0b want %0b", n, out_valid, q.size() > 0); end
            tests++; if (occupancy !== 2'(q.size())) begin fails++; $display("[TB] FAIL rnd_occupancy cyc %0d got %0d want %0d", n, occupancy, q.size()); end
            tests++; if (in_ready !== (q.size() < 2)) begin fails++; $display("[TB] FAIL rnd_in_ready cyc %0d got %0b want %0b", n, in_ready, q.size() < 2); end
            tests++; if (stall_cnt !== 16'(mstall)) begin fails++; $display("[TB] FAIL rnd_stall cyc %0d got %0d want %0d", n, stall_cnt, mstall); end
            if (q.size() > 0) begin
                tests++; if (out_pay !== q[0]) begin fails++; $display("[TB] FAIL rnd_payload cyc %0d got %h want %h", n, out_pay, q[0]); end
            end else begin
                tests++; if ({wb_en_out, mem_read_en_out, mem_write_en_out} !== 3'b000) begin fails++; $display("[TB] FAIL rnd_flags_idle cyc %0d got %b want 000", n, {wb_en_out, mem_read_en_out, mem_write_en_out}); end
            end
            model_step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_step();
        model_step();
    endtask

    task automatic test_no_skid();
        logic [DW-1:0] held;
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        set_payload(32'h100, 4'd1);
        #1;
        tests++; if (in_ready0 !== 1'b1) begin fails++; $display("[TB] FAIL noskid_ready_empty got %0b want 1", in_ready0); end
        @(posedge clk); @(negedge clk);
        set_payload(32'h200, 4'd2);
        #1;
        tests++; if (in_ready0 !== 1'b0) begin fails++; $display("[TB] FAIL noskid_ready_stall got %0b want 0", in_ready0); end
        tests++; if (occupancy0 !== 2'd1) begin fails++; $display("[TB] FAIL noskid_occ_stall got %0d want 1", occupancy0); end
        @(posedge clk); @(negedge clk);
        held = 32'h100;
        out_ready0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_payload(32'h300 + i, 4'(i));
            #1;
            tests++; if (in_ready0 !== 1'b1) begin fails++; $display("[TB] FAIL noskid_ready_flow got %0b want 1", in_ready0); end
            tests++; if (alu_res_out0 !== held) begin fails++; $display("[TB] FAIL noskid_replace got %h want %h", alu_res_out0, held); end
            tests++; if (occupancy0 !== 2'd1) begin fails++; $display("[TB] FAIL noskid_occ_flow got %0d want 1", occupancy0); end
            held = 32'h300 + i;
            @(posedge clk); @(negedge clk);
        end
        in_valid0 = 1'b0;
        #1;
        tests++; if (alu_res_out0 !== 32'h303) begin fails++; $display("[TB] FAIL noskid_last got %h want 303", alu_res_out0); end
        @(posedge clk); @(negedge clk);
        tests++; if (out_valid0 !== 1'b0) begin fails++; $display("[TB] FAIL noskid_drain got %0b want 0", out_valid0); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_payload(32'h900, 4'd3);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        tests++; if (stall_cnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL sat_value got %h want FFFF", stall_cnt); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++; if (stall_cnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL sat_hold got %h want FFFF", stall_cnt); end
        rst = 1'b1;
        #1;
        tests++; if (stall_cnt !== 16'd0) begin fails++; $display("[TB] FAIL sat_reset got %h want 0", stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        mstall     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_valid0  = 1'b0;
        out_ready  = 1'b0;
        out_ready0 = 1'b0;
        flush      = 1'b0;
        wb_en        = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        alu_res      = '0;
        val_rm       = '0;
        dest         = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        test_no_skid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
